// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - data-memory access controller for the pixel RAM
//
// Runs one load or store per four-phase handshake against a synchronous
// single-port RAM. The control unit holds mem_op until done, then drops it
// to 00. All outputs are registered.
//
// Optional feature: define DMEM_BOUND_CHK_EN to reject accesses with
// dm_addr >= MEM_DEPTH (and the reserved op 11) with err=1 and no RAM access.
//
// Ports:
//   clk, rst_n  - rising-edge clock, asynchronous active-low reset
//   mem_op      - 00 none, 01 load, 10 store, 11 reserved
//   dm_addr     - access address from the register file
//   dm_data     - store data from the register file
//   mem_data    - load result, held until the next load completes
//   busy        - access in flight
//   done        - access complete, waiting for mem_op=00
//   err         - out-of-range access, valid while done=1
//   ram_en, ram_we, ram_addr, ram_wdata - RAM command
//   ram_rdata   - RAM read data, RD_LAT clocks after the RAM samples ram_en
module dmem_ctrl #(
  parameter int ADDR_W    = 19,
  parameter int DATA_W    = 8,
  parameter int RD_LAT    = 1,
  parameter int MEM_DEPTH = 65536
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        mem_op,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_data,
  output logic [DATA_W-1:0] mem_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int CNT_W = $clog2(RD_LAT + 1);
  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_LD   = 2'b01;
  localparam logic [1:0] OP_ST   = 2'b10;

  if (RD_LAT < 1 || RD_LAT > 4 || MEM_DEPTH < 1) begin : g_param_chk
    $error("dmem_ctrl: RD_LAT must be 1..4 and MEM_DEPTH positive");
  end

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] mem_data_q, mem_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ram_en_q, ram_en_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;

`ifdef DMEM_BOUND_CHK_EN
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(MEM_DEPTH);
  // A rejected access travels through WR with the RAM strobes left low;
  // bad_q marks it and ld_q remembers whether mem_data must be cleared.
  logic err_q, err_d;
  logic bad_q, bad_d;
  logic ld_q, ld_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mem_data_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
`ifdef DMEM_BOUND_CHK_EN
      err_q       <= 1'b0;
      bad_q       <= 1'b0;
      ld_q        <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_data_q  <= mem_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
`ifdef DMEM_BOUND_CHK_EN
      err_q       <= err_d;
      bad_q       <= bad_d;
      ld_q        <= ld_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_data_d  = mem_data_q;
    busy_d      = busy_q;
    done_d      = done_q;
    ram_en_d    = ram_en_q;
    ram_we_d    = ram_we_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
`ifdef DMEM_BOUND_CHK_EN
    err_d       = err_q;
    bad_d       = bad_q;
    ld_d        = ld_q;
`endif

    case (state_q)
      IDLE: begin
`ifdef DMEM_BOUND_CHK_EN
        if (mem_op == 2'b11 ||
            ((mem_op == OP_LD || mem_op == OP_ST) && {1'b0, dm_addr} >= DEPTH_X)) begin
          busy_d  = 1'b1;
          bad_d   = 1'b1;
          ld_d    = (mem_op == OP_LD);
          state_d = WR;
        end else
`endif
        if (mem_op == OP_LD) begin
          ram_addr_d = dm_addr;
          ram_en_d   = 1'b1;
          busy_d     = 1'b1;
          cnt_d      = '0;
          state_d    = RD;
        end else if (mem_op == OP_ST) begin
          ram_addr_d  = dm_addr;
          ram_wdata_d = dm_data;
          ram_en_d    = 1'b1;
          ram_we_d    = 1'b1;
          busy_d      = 1'b1;
          state_d     = WR;
        end
      end

      RD: begin
        // cnt holds the number of edges spent in RD; the RAM sampled ram_en
        // at the first of them, so data is ready once RD_LAT more have passed.
        ram_en_d = 1'b0;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(RD_LAT)) begin
          mem_data_d = ram_rdata;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          state_d    = DONE;
        end
      end

      WR: begin
        // The RAM commits the write on this edge.
        ram_en_d = 1'b0;
        ram_we_d = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b1;
        state_d  = DONE;
`ifdef DMEM_BOUND_CHK_EN
        bad_d = 1'b0;
        if (bad_q) begin
          err_d = 1'b1;
          if (ld_q) mem_data_d = '0;
        end
`endif
      end

      DONE: begin
        // Returning to IDLE only after seeing 00 keeps a held op from
        // launching a second access.
        if (mem_op == OP_NONE) begin
          done_d  = 1'b0;
          state_d = IDLE;
`ifdef DMEM_BOUND_CHK_EN
          err_d   = 1'b0;
`endif
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign mem_data  = mem_data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign ram_en    = ram_en_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
`ifdef DMEM_BOUND_CHK_EN
  assign err       = err_q;
`else
  assign err       = 1'b0;
`endif

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Data-memory access controller between the register file and the on-chip pixel RAM of the downsampling processor.
- Takes the register file's memory address (dm_addr), store data (dm_data) and the control unit's MEM op. Runs one load or store against a synchronous single-port RAM.
- Returns load data as mem_data into the register file.
- Handshake with the control unit is four-phase: op held until done, then dropped to 00.

Parameters:
ADDR_W, 19, address width; matches register-file dm_addr.
DATA_W, 8, pixel/data width.
RD_LAT, 1, RAM read latency in clocks, legal range 1..4.
MEM_DEPTH, 65536, number of valid RAM words; used only when DMEM_BOUND_CHK_EN is defined.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
mem_op  in  2  MEM op: 00 none, 01 load, 10 store, 11 reserved.
dm_addr  in  ADDR_W  access address from the register file.
dm_data  in  DATA_W  store data from the register file.
mem_data  out  DATA_W  load result to the register file; registered and held.
busy  out  1  high while an access is in flight.
done  out  1  high while an access is complete and awaiting mem_op=00.
err  out  1  out-of-range access flag, valid while done=1.
ram_en  out  1  RAM enable.
ram_we  out  1  RAM write enable.
ram_addr  out  ADDR_W  RAM address.
ram_wdata  out  DATA_W  RAM write data.
ram_rdata  in  DATA_W  RAM read data, valid RD_LAT clocks after the RAM samples ram_en.

Behaviour:
- Reset (async, any state): state=IDLE; mem_data, ram_addr, ram_wdata = 0; busy, done, err, ram_en, ram_we = 0.
- All outputs are registered.
- States: IDLE, RD, WR, DONE.
- IDLE, edge E0, mem_op=01:
  - latch ram_addr<=dm_addr; ram_en<=1; busy<=1; cnt<=0; go to RD.
- IDLE, edge E0, mem_op=10:
  - ram_addr<=dm_addr; ram_wdata<=dm_data; ram_en<=1; ram_we<=1; busy<=1; go to WR.
- IDLE, mem_op=00 or 11: stay in IDLE, no RAM activity.
- RD:
  - ram_en<=0 at E1.
  - cnt increments each edge.
  - At edge E(1+RD_LAT): mem_data<=ram_rdata; busy<=0; done<=1; go to DONE.
  - Load latency = 1+RD_LAT edges after the sampling edge.
- WR:
  - At E1 (RAM writes at this edge): ram_en<=0; ram_we<=0; busy<=0; done<=1; go to DONE.
  - Store latency = 1 edge.
- DONE:
  - Hold done=1 until mem_op=00 is sampled.
  - Then done<=0, err<=0, go to IDLE.
  - The next op is accepted no earlier than the following edge, which guarantees no re-trigger from a held op.
- mem_op, dm_addr and dm_data changes while busy are ignored; values are latched at E0.
- mem_data changes only on load completion. Stores and reset-free idle cycles leave it unchanged.
- busy and done are never high together.
- ram_we is high for exactly one cycle per store and never during loads.
- Reset mid-access: RAM strobes drop immediately (async). A store aborted before its RAM edge is not written.
- Counter width is ceil(log2(RD_LAT+1)). Wrap is impossible given the legal RD_LAT range.

Optional Feature:
Macro DMEM_BOUND_CHK_EN.
- Defined:
  - In IDLE, a load/store with dm_addr >= MEM_DEPTH issues no RAM access (ram_en, ram_we stay 0).
  - Goes to DONE at E1 with err=1.
  - Load: mem_data<=0. Store: nothing written.
  - mem_op=11 in IDLE also goes to DONE at E1 with err=1.
- Undefined:
  - No range check; the address passes straight through to the RAM.
  - mem_op=11 is ignored.
  - err is tied to 0.

Test Plan:
1. Reset: rst_n=0 asynchronously mid-store (ram_we=1) -> ram_we and all outputs 0 before the next clk edge; state IDLE after release.
2. Store then load, RD_LAT=1: store addr=10, data=8'hA5, hold until done, drop op; then load addr=10 with the RAM model -> ram_we high exactly 1 cycle; load done 2 edges after sampling; mem_data=8'hA5.
3. RD_LAT=3 load: addr=19'd65535 preloaded with 8'h3C -> done asserts 4 edges after the sampling edge; mem_data=8'h3C; busy high for 4 cycles.
4. Held op: keep mem_op=01 for 10 cycles after done -> exactly one RAM read (ram_en pulses once); done stays high until mem_op=00, then clears on the next edge.
5. Ignore while busy: during an RD_LAT=2 load of addr 5, switch mem_op=10 and dm_addr=7 -> no write; the load returns addr 5 data; mem_data is unchanged by any store.
6. DMEM_BOUND_CHK_EN, MEM_DEPTH=65536: load addr=65536 -> ram_en never asserted; done at E1 with err=1 and mem_data=0. Without the macro: the same access reaches the RAM and err=0.
